regfile_wb: RTL and testbench



---
 rtl/processor_pkg.sv | 23 ++
 rtl/regfile_array.sv | 56 +++++
 rtl/regfile_wb.sv | 115 +++++++++++
 tb/tb_regfile_wb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/processor_pkg.sv
// processor_pkg -- shared types and constants for the integer register file.
//
// Contents:
//   XLEN        default data width of registers and result bus
//   REG_ADDR_W  width of a register index (32 architectural registers)
//   NUM_REGS    number of architectural registers
//   reg_addr_t  register index type
//   wb_entry_t  one write-back entry: valid flag, destination index, data
package processor_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic             valid;
    reg_addr_t        addr;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_array.sv
// regfile_array -- 32 x XLEN integer register storage.
//
// One synchronous write port, two combinational read ports. Index 0 has
// no storage and always reads as zero. All storage clears on the
// asynchronous active-low reset.
//
// Ports:
//   clk      in   core clock
//   rst_n    in   asynchronous active-low reset
//   we       in   write enable
//   waddr    in   write index
//   wdata    in   write data
//   raddr1   in   read port 1 index
//   raddr2   in   read port 2 index
//   rdata1   out  read port 1 data (combinational)
//   rdata2   out  read port 2 data (combinational)
module regfile_array
  import processor_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  reg_addr_t       waddr,
  input  logic [XLEN-1:0] wdata,
  input  reg_addr_t       raddr1,
  input  reg_addr_t       raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        // x0 is hard-wired; no flops exist for it.
        assign regs_q[gi] = '0;
      end else begin : g_flop
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            regs_q[gi] <= '0;
          end else if (we && (waddr == reg_addr_t'(gi))) begin
            regs_q[gi] <= wdata;
          end
        end
      end
    end
  endgenerate

  assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/regfile_wb.sv
// regfile_wb -- integer register file with a registered write-back stage.
//
// An ALU result is captured into a one-entry pending register, then
// committed into the array on the following edge. The pending status is
// exported so the hazard unit can decide stalls.
//
// Build option: define REGFILE_BYPASS_EN to let reads that hit the pending
// entry return its data (RAW distance 1). Without it, reads see the array
// only (RAW distance 2).
//
// Ports:
//   clk               in   core clock
//   rst_n             in   asynchronous active-low reset
//   wb_valid          in   ALU result presented this cycle
//   rd_write_control  in   presented result is to be written
//   rd_addr           in   destination register index
//   rd_write_val      in   result value
//   rs1_addr          in   source register 1 index
//   rs2_addr          in   source register 2 index
//   rs1_val           out  source register 1 value (combinational)
//   rs2_val           out  source register 2 value (combinational)
//   wb_pending        out  pending entry holds an uncommitted write
//   wb_pending_addr   out  pending destination index, 0 when none pending
module regfile_wb
  import processor_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic            rd_write_control,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_write_val,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            wb_pending,
  output logic [4:0]      wb_pending_addr
);

  logic            pend_valid_q, pend_valid_d;
  reg_addr_t       pend_addr_q,  pend_addr_d;
  logic [XLEN-1:0] pend_data_q,  pend_data_d;
  logic            capture;

  // Writes to x0 are dropped here so they never reach the array or bypass.
  assign capture = wb_valid & rd_write_control & (rd_addr != '0);

  always_comb begin
    pend_valid_d = capture;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    if (capture) begin
      pend_addr_d = rd_addr;
      pend_data_d = rd_write_val;
    end
  end

  // Reset discards the pending entry: it never gets committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  reg_addr_t       rd_idx [2];
  logic [XLEN-1:0] arr_val [2];
  logic [XLEN-1:0] rd_val [2];

  assign rd_idx[0] = rs1_addr;
  assign rd_idx[1] = rs2_addr;

  regfile_array #(
    .XLEN (XLEN)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (pend_valid_q),
    .waddr  (pend_addr_q),
    .wdata  (pend_data_q),
    .raddr1 (rd_idx[0]),
    .raddr2 (rd_idx[1]),
    .rdata1 (arr_val[0]),
    .rdata2 (arr_val[1])
  );

  // Read muxes select only between registered sources; rd_write_val never
  // feeds a read port since the ALU closes a loop between them.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
      logic hit;
      assign hit        = pend_valid_q && (rd_idx[gi] == pend_addr_q) && (rd_idx[gi] != '0);
      assign rd_val[gi] = hit ? pend_data_q : arr_val[gi];
`else
      assign rd_val[gi] = arr_val[gi];
`endif
    end
  endgenerate

  assign rs1_val         = rd_val[0];
  assign rs2_val         = rd_val[1];
  assign wb_pending      = pend_valid_q;
  assign wb_pending_addr = pend_valid_q ? pend_addr_q : '0;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

  localparam int XLEN = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_valid = 1'b0;
  logic            rd_write_control = 1'b0;
  logic [4:0]      rd_addr = '0;
  logic [XLEN-1:0] rd_write_val = '0;
  logic [4:0]      rs1_addr = '0;
  logic [4:0]      rs2_addr = '0;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            wb_pending;
  logic [4:0]      wb_pending_addr;

  regfile_wb #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_valid         (wb_valid),
    .rd_write_control (rd_write_control),
    .rd_addr          (rd_addr),
    .rd_write_val     (rd_write_val),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_val          (rs1_val),
    .rs2_val          (rs2_val),
    .wb_pending       (wb_pending),
    .wb_pending_addr  (wb_pending_addr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference state built from the behavioural description.
  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_pa;
  logic [31:0] m_pd;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && m_pv && (m_pa == a)) return m_pd;
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_pv = 1'b0;
    m_pa = 5'd0;
    m_pd = 32'h0;
  endtask

  // Scoreboard: kind 0=rs1, 1=rs2, 2=wb_pending, 3=wb_pending_addr.
  string       q_tag [$];
  int          q_kind [$];
  logic [31:0] q_exp [$];

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    q_tag.push_back(tag);
    q_kind.push_back(kind);
    q_exp.push_back(exp);
  endtask

  task automatic drain();
    logic [31:0] obs;
    while (q_exp.size() > 0) begin
      string       t;
      int          k;
      logic [31:0] e;
      t = q_tag.pop_front();
      k = q_kind.pop_front();
      e = q_exp.pop_front();
      case (k)
        0:       obs = rs1_val;
        1:       obs = rs2_val;
        2:       obs = {31'b0, wb_pending};
        default: obs = {27'b0, wb_pending_addr};
      endcase
      chk(t, obs, e);
    end
  endtask

  // One clock cycle: drive, push expectations, sample at negedge, clock model.
  task automatic step(input string tag, input logic wv, input logic wc, input logic [4:0] ra,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    wb_valid = wv; rd_write_control = wc; rd_addr = ra; rd_write_val = wd;
    rs1_addr = r1; rs2_addr = r2;
    push({tag, "_rs1"}, 0, m_read(r1));
    push({tag, "_rs2"}, 1, m_read(r2));
    push({tag, "_pend"}, 2, {31'b0, m_pv});
    push({tag, "_paddr"}, 3, m_pv ? {27'b0, m_pa} : 32'h0);
    @(negedge clk);
    drain();
    @(posedge clk);
    if (m_pv) m_regs[m_pa] = m_pd;
    if (wv && wc && (ra != 5'd0)) begin
      m_pv = 1'b1; m_pa = ra; m_pd = wd;
    end else begin
      m_pv = 1'b0;
    end
    #1;
    $display("[TB] %s wv=%0d wc=%0d x%0d<=%h rs1=x%0d:%h rs2=x%0d:%h", tag, wv, wc, ra, wd,
             r1, rs1_val, r2, rs2_val);
  endtask

  task automatic idle_inputs();
    wb_valid = 1'b0; rd_write_control = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write x5 <= DEADBEEF, rs1 held at 5.
    step("basic_c0", 1, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    idle_inputs(); #1;
    chk("basic_c1_pend", {31'b0, wb_pending}, 32'h1);
    chk("basic_c1_paddr", {27'b0, wb_pending_addr}, 32'd5);
    chk("basic_c1_rs1", rs1_val, BYP ? 32'hDEADBEEF : 32'h0);
    step("basic_c1", 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("basic_c2_rs1", rs1_val, 32'hDEADBEEF);
    step("basic_c2", 0, 0, 5'd0, 32'h0, 5'd5, 5'd5);

    // x0 write is dropped.
    step("x0_wr", 1, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
    idle_inputs(); #1;
    chk("x0_pend", {31'b0, wb_pending}, 32'h0);
    chk("x0_rs2", rs2_val, 32'h0);

    // Disabled write leaves x7 alone.
    step("x7_wr", 1, 1, 5'd7, 32'h77, 5'd7, 5'd0);
    step("x7_dis", 1, 0, 5'd7, 32'h999, 5'd7, 5'd7);
    step("x7_idle0", 0, 0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("x7_kept", rs1_val, 32'h77);
    step("x7_idle1", 0, 0, 5'd0, 32'h0, 5'd7, 5'd7);

    // Back-to-back writes to x3.
    step("b2b_c0", 1, 1, 5'd3, 32'h11, 5'd3, 5'd0);
    step("b2b_c1", 1, 1, 5'd3, 32'h22, 5'd3, 5'd3);
    idle_inputs(); rs1_addr = 5'd3; #1;
    chk("b2b_c2_rs1", rs1_val, BYP ? 32'h22 : 32'h11);
    step("b2b_c2", 0, 0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("b2b_c3_rs1", rs1_val, 32'h22);
    step("b2b_c3", 0, 0, 5'd0, 32'h0, 5'd3, 5'd3);

    // Reset mid-operation: pending x9 is discarded.
    step("rst_cap", 1, 1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd3);
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    m_clear();
    chk("midrst_pend", {31'b0, wb_pending}, 32'h0);
    chk("midrst_x3", rs2_val, 32'h0);
    #1 rst_n = 1'b1;
    step("rst_after0", 0, 0, 5'd0, 32'h0, 5'd9, 5'd3);
    step("rst_after1", 0, 0, 5'd0, 32'h0, 5'd9, 5'd5);
    chk("midrst_x9", rs1_val, 32'h0);

    // Sustained writes xi <= i*01010101.
    for (int i = 0; i < 32; i++) begin
      step($sformatf("sus_w%0d", i), 1, 1, 5'(i), 32'(i) * 32'h01010101, 5'(i), 5'(31 - i));
    end
    step("sus_idle0", 0, 0, 5'd0, 32'h0, 5'd31, 5'd30);
    step("sus_idle1", 0, 0, 5'd0, 32'h0, 5'd31, 5'd30);
    for (int i = 0; i < 32; i++) begin
      step($sformatf("sus_r%0d", i), 0, 0, 5'd0, 32'h0, 5'(i), 5'((i + 1) % 32));
      chk($sformatf("sus_c%0d", i), rs1_val, (i == 0) ? 32'h0 : 32'(i) * 32'h01010101);
    end

    // Full reset, then read all 32 indices.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_clear();
    chk("rst_pend", {31'b0, wb_pending}, 32'h0);
    chk("rst_paddr", {27'b0, wb_pending_addr}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #0.1;
      chk($sformatf("rst_r1_x%0d", i), rs1_val, 32'h0);
      chk($sformatf("rst_r2_x%0d", 31 - i), rs2_val, 32'h0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    step("rst_done", 0, 0, 5'd0, 32'h0, 5'd5, 5'd31);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
